// File: rtl/gat_feat_drain.sv
// rtl/gat_feat_drain.sv - streams the GAT new-feature BRAM out as a credit-controlled AXI-Stream
module gat_feat_drain #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int RD_LATENCY         = 1,
  parameter int FIFO_DEPTH         = 4,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          drain_busy,
  output logic                          drain_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int FEAT_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX  = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [FEAT_W-1:0]             LAST_FEAT = FEAT_W'(NUM_FEATURE_OUT - 1);
  localparam logic [CNT_W:0]                CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t                          r_state;
  logic                            r_armed;
  logic                            r_busy;
  logic                            r_done;
  logic [NEW_FEATURE_ADDR_W-1:0]   r_rd_idx;
  logic [FEAT_W-1:0]               r_feat_idx;
  logic [NEW_FEATURE_ADDR_W+1:0]   r_addr_hold;
  logic [RD_LATENCY-1:0]           r_pipe_vld;
  logic [RD_LATENCY-1:0]           r_pipe_last;
  logic [CNT_W-1:0]                r_inflight;
  logic [CNT_W-1:0]                r_fifo_count;
  logic [PTR_W-1:0]                r_wr_ptr;
  logic [PTR_W-1:0]                r_rd_ptr;
  logic [NEW_FEATURE_WIDTH:0]      r_mem [0:FIFO_DEPTH-1];

  logic [CNT_W:0]                  w_used;
  logic                            w_issue;
  logic                            w_push;
  logic                            w_pop;
  logic                            w_valid;
  logic                            w_start;
  logic                            w_drained;
  logic [NEW_FEATURE_WIDTH:0]      w_head;

  // A read is only issued when a FIFO slot is already reserved for its data,
  // so words returning from the BRAM pipe can always be written.
  assign w_used    = {1'b0, r_fifo_count} + {1'b0, r_inflight};
  assign w_issue   = (r_state == S_DRAIN) && (w_used < CREDITS);
  assign w_push    = r_pipe_vld[RD_LATENCY-1];
  assign w_valid   = (r_fifo_count != '0);
  assign w_pop     = w_valid && m_tready;
  assign w_start   = (r_state == S_IDLE) && r_armed && gat_ready;
  assign w_drained = (r_inflight == '0) && !w_push &&
                     ((r_fifo_count == '0) || ((r_fifo_count == CNT_W'(1)) && w_pop));
  assign w_head    = r_mem[r_rd_ptr];

  // Address tracks the read being issued this cycle, otherwise holds the last one.
  assign feat_bram_addrb = w_issue ? {r_rd_idx, 2'b00} : r_addr_hold;
  assign m_tvalid        = w_valid;
  assign m_tdata         = w_valid ? w_head[NEW_FEATURE_WIDTH-1:0] : '0;
  assign m_tlast         = w_valid ? w_head[NEW_FEATURE_WIDTH] : 1'b0;
  assign drain_busy      = r_busy;
  assign drain_done      = r_done;

  // Drain sequencer: arming, read index walk, flush and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_idx    <= '0;
      r_feat_idx  <= '0;
      r_addr_hold <= '0;
    end else begin
      r_done <= 1'b0;
      if (!gat_ready) begin
        r_armed <= 1'b1;
      end else if (w_start) begin
        r_armed <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_DRAIN;
            r_rd_idx   <= '0;
            r_feat_idx <= '0;
            r_busy     <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_issue) begin
            r_addr_hold <= {r_rd_idx, 2'b00};
            r_feat_idx  <= (r_feat_idx == LAST_FEAT) ? '0 : r_feat_idx + 1'b1;
            if (r_rd_idx == LAST_IDX) begin
              r_state <= S_FLUSH;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (w_drained) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Valid/last tag pipe matching the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_issue && (r_feat_idx == LAST_FEAT);
    end
  end

  // Credit bookkeeping: reads in flight, FIFO occupancy and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight   <= '0;
      r_fifo_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      if (w_issue && !w_push) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (!w_issue && w_push) begin
        r_inflight <= r_inflight - 1'b1;
      end
      if (w_push && !w_pop) begin
        r_fifo_count <= r_fifo_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_fifo_count <= r_fifo_count - 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until the count covers them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_pipe_last[RD_LATENCY-1], feat_bram_dout};
    end
  end

endmodule

// File: tb/tb_gat_feat_drain.sv
// tb/tb_gat_feat_drain.sv - randomized scoreboard bench for gat_feat_drain at read latencies 1 and 2
module tb_gat_feat_drain;

  localparam int NS    = 3;
  localparam int NF    = 4;
  localparam int DEPTH = NS * NF;
  localparam int AW    = $clog2(DEPTH) + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gat_ready = 1'b0;
  logic m_tready = 1'b0;
  int   rdy_mode = 1;
  int   cyc = 0;
  int   t_start = 0;
  bit   lat_check = 1'b0;
  bit   model_armed = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [1:0][AW-1:0] addrb;
  logic [1:0][31:0]   dout;
  logic [1:0][31:0]   tdata;
  logic [1:0]         tvalid;
  logic [1:0]         tlast;
  logic [1:0]         busy;
  logic [1:0]         done;

  logic [32:0] exp_q [$];
  int          rp [2];
  int          done_cnt [2];
  int          acc_cnt [2];
  int          acc_drain [2];
  int          max_idx [2];
  int          last_acc_cyc [2];
  bit          first_pend [2];
  bit          p_hold [2];
  logic        p_busy [2];
  logic [32:0] p_word [2];
  logic [AW-1:0] p_addr [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = g + 1;
    logic [AW-1:0] a_d [3];

    // BRAM model: word at index i reads as 0xA000+i, L cycles after the address.
    always @(posedge clk) begin
      a_d[0] <= addrb[g];
      a_d[1] <= a_d[0];
      a_d[2] <= a_d[1];
    end
    assign dout[g] = 32'hA000 + {28'd0, a_d[L-1][AW-1:2]};

    gat_feat_drain #(
      .NEW_FEATURE_WIDTH(32),
      .NUM_SUBGRAPHS(NS),
      .NUM_FEATURE_OUT(NF),
      .RD_LATENCY(L),
      .FIFO_DEPTH(4)
    ) dut (
      .clk(clk),
      .rst(rst),
      .gat_ready(gat_ready),
      .feat_bram_addrb(addrb[g]),
      .feat_bram_dout(dout[g]),
      .m_tdata(tdata[g]),
      .m_tvalid(tvalid[g]),
      .m_tready(m_tready),
      .m_tlast(tlast[g]),
      .drain_busy(busy[g]),
      .drain_done(done[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one full drain per armed rising gat_ready.
  always @(posedge clk) begin
    logic [32:0] e;
    if (rst) begin
      model_armed <= 1'b0;
    end else if (!gat_ready) begin
      model_armed <= 1'b1;
    end else if (model_armed) begin
      model_armed <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        e = {((i % NF) == NF - 1), 32'(32'hA000 + i)};
        exp_q.push_back(e);
      end
    end
  end

  // Downstream ready: 0, 1, or random with 30% acceptance.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = ($urandom_range(0, 99) < 30);
    endcase
  end

  // Monitor for both instances.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        rp[g]     = exp_q.size();
        p_hold[g] = 1'b0;
      end else begin
        if (p_hold[g]) begin
          check($sformatf("L%0d stall_valid", g + 1), tvalid[g], 1);
          check($sformatf("L%0d stall_word", g + 1), {tlast[g], tdata[g]}, p_word[g]);
        end
        if (busy[g] && !p_busy[g]) begin
          check($sformatf("L%0d first_addr", g + 1), addrb[g], 0);
          if (lat_check) check($sformatf("L%0d busy_latency", g + 1), cyc - t_start, 1);
          max_idx[g]    = 0;
          acc_drain[g]  = 0;
          first_pend[g] = 1'b1;
        end else if (busy[g] && addrb[g] != p_addr[g]) begin
          check($sformatf("L%0d addr_step", g + 1), addrb[g], p_addr[g] + 4);
          max_idx[g] = int'(addrb[g] >> 2);
        end
        if (busy[g]) begin
          check($sformatf("L%0d credit", g + 1), (max_idx[g] + 1 - acc_drain[g]) <= 4, 1);
        end
        if (tvalid[g] && first_pend[g]) begin
          if (lat_check) check($sformatf("L%0d valid_latency", g + 1), cyc - t_start, g + 3);
          first_pend[g] = 1'b0;
        end
        if (tvalid[g] && m_tready) begin
          if (rp[g] < exp_q.size()) begin
            check($sformatf("L%0d word%0d", g + 1, rp[g]), {tlast[g], tdata[g]}, exp_q[rp[g]]);
            rp[g]++;
          end else begin
            n_checks++;
            n_fail++;
            $display("FAIL L%0d extra_word: got 0x%0h, expected no word", g + 1, tdata[g]);
          end
          acc_drain[g]++;
          acc_cnt[g]++;
          last_acc_cyc[g] = cyc;
        end
        if (done[g]) begin
          done_cnt[g]++;
          check($sformatf("L%0d done_after_accept", g + 1), cyc - last_acc_cyc[g], 1);
          check($sformatf("L%0d all_delivered", g + 1), rp[g], exp_q.size());
          check($sformatf("L%0d final_addr", g + 1), addrb[g], 6'h2C);
          check($sformatf("L%0d busy_at_done", g + 1), busy[g], 0);
          check($sformatf("L%0d done_single", g + 1), p_busy[g] === 1'b1 || !done[g], 1);
        end
        p_hold[g] = tvalid[g] && !m_tready;
      end
      p_word[g] = {tlast[g], tdata[g]};
      p_busy[g] = busy[g];
      p_addr[g] = addrb[g];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n, input string what);
    int k = 0;
    while ((done_cnt[0] < n || done_cnt[1] < n) && k < 1000) begin
      step(1);
      k++;
    end
    check({what, "_completes"}, k < 1000, 1);
  endtask

  initial begin
    int base;
    int k;
    for (int g = 0; g < 2; g++) begin
      rp[g] = 0; done_cnt[g] = 0; acc_cnt[g] = 0; acc_drain[g] = 0;
      max_idx[g] = 0; last_acc_cyc[g] = 0; first_pend[g] = 1'b0;
      p_hold[g] = 1'b0; p_busy[g] = 1'b0; p_word[g] = '0; p_addr[g] = '0;
    end
    step(3);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("L%0d rst_addr", g + 1), addrb[g], 0);
      check($sformatf("L%0d rst_tvalid", g + 1), tvalid[g], 0);
      check($sformatf("L%0d rst_tdata", g + 1), tdata[g], 0);
      check($sformatf("L%0d rst_tlast", g + 1), tlast[g], 0);
      check($sformatf("L%0d rst_busy", g + 1), busy[g], 0);
      check($sformatf("L%0d rst_done", g + 1), done[g], 0);
    end
    rst = 1'b0;
    step(2);

    // basic drain, ready held high
    rdy_mode  = 1;
    lat_check = 1'b1;
    gat_ready = 1'b1;
    t_start   = cyc;
    wait_done(1, "basic");
    lat_check = 1'b0;

    // gat_ready still high: no second drain
    step(30);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("L%0d no_rearm_busy", g + 1), busy[g], 0);
      check($sformatf("L%0d no_rearm_done_cnt", g + 1), done_cnt[g], 1);
    end

    // re-arm with random backpressure
    gat_ready = 1'b0;
    step(1);
    gat_ready = 1'b1;
    rdy_mode  = 2;
    wait_done(2, "backpressure");

    // full stall for 50 cycles
    gat_ready = 1'b0;
    rdy_mode  = 0;
    step(1);
    gat_ready = 1'b1;
    step(50);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("L%0d stall_addr", g + 1), addrb[g], 6'h0C);
      check($sformatf("L%0d stall_tvalid", g + 1), tvalid[g], 1);
      check($sformatf("L%0d stall_tdata", g + 1), tdata[g], 32'hA000);
    end
    rdy_mode = 2;
    wait_done(3, "stall_release");

    // gat_ready dropped mid-drain
    gat_ready = 1'b0;
    step(1);
    gat_ready = 1'b1;
    step(6);
    gat_ready = 1'b0;
    wait_done(4, "drop");

    // reset after the 5th accepted word
    gat_ready = 1'b1;
    base = acc_cnt[0];
    k = 0;
    while (acc_cnt[0] < base + 5 && k < 500) begin
      step(1);
      k++;
    end
    check("reset_drain_progress", k < 500, 1);
    rst = 1'b1;
    step(1);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("L%0d abort_tvalid", g + 1), tvalid[g], 0);
      check($sformatf("L%0d abort_busy", g + 1), busy[g], 0);
      check($sformatf("L%0d abort_addr", g + 1), addrb[g], 0);
    end
    rst = 1'b0;
    step(20);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("L%0d post_rst_idle", g + 1), busy[g], 0);
      check($sformatf("L%0d post_rst_tvalid", g + 1), tvalid[g], 0);
    end
    gat_ready = 1'b0;
    step(1);
    gat_ready = 1'b1;
    rdy_mode  = 1;
    wait_done(5, "after_reset");
    step(5);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("L%0d total_done", g + 1), done_cnt[g], 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
